// File: rtl/fish_pkg.sv
// Shared fish definitions: lifecycle states, direction codes and screen geometry.
// The fish motion generator imports this package as well.
package fish_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWIM   = 2'd1,
        ST_HOOKED = 2'd2,
        ST_EXIT   = 2'd3
    } fish_state_e;

    localparam logic [1:0] WAY_LEFT  = 2'd0;
    localparam logic [1:0] WAY_RIGHT = 2'd1;
    localparam logic [1:0] WAY_UP    = 2'd2;

    localparam int unsigned H_MAX_DEF     = 720;
    localparam int unsigned V_MIN_DEF     = 200;
    localparam int unsigned V_MAX_DEF     = 460;
    localparam int unsigned V_SURFACE_DEF = 120;

    // Saturate a 10-bit coordinate into [lo, hi].
    function automatic logic [9:0] clamp10(input logic [9:0] val,
                                           input logic [9:0] lo,
                                           input logic [9:0] hi);
        if (val < lo)      return lo;
        else if (val > hi) return hi;
        else               return val;
    endfunction

endpackage

// File: rtl/fish_tick_gen.sv
// Free-running H_DIV divider with synchronous clear; tick_o marks the last
// count of each period, so the first tick lands H_DIV cycles after a clear.
module fish_tick_gen #(
    parameter int unsigned H_DIV = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (H_DIV > 2) ? $clog2(H_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(H_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Next count: wrap at the end of the period, restart on clear.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) cnt_d = '0;
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fish_position.sv
// One fish: coordinates, horizontal drift, vertical steps and the
// idle -> swim -> hooked -> exit lifecycle. All outputs are registered.
module fish_position
    import fish_pkg::*;
#(
    parameter int unsigned H_MAX     = H_MAX_DEF,
    parameter int unsigned V_MIN     = V_MIN_DEF,
    parameter int unsigned V_MAX     = V_MAX_DEF,
    parameter int unsigned V_SURFACE = V_SURFACE_DEF,
    parameter int unsigned H_DIV     = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn,
    input  logic [1:0] spawn_way,
    input  logic [9:0] spawn_h,
    input  logic [9:0] spawn_v,
    input  logic       vm,
    input  logic       up,
    input  logic       hook,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic [1:0] way,
    output logic       appear,
    output logic       done,
    output logic       caught
);

    localparam logic [9:0]  H_MAX_W  = 10'(H_MAX);
    localparam logic [9:0]  V_MIN_W  = 10'(V_MIN);
    localparam logic [9:0]  V_MAX_W  = 10'(V_MAX);
    localparam logic [10:0] V_REEL_W = 11'(V_SURFACE + 1);

    fish_state_e state_q, state_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [1:0]  way_q, way_d;
    logic        appear_q, appear_d;
    logic        done_q, done_d;
    logic        caught_q, caught_d;

    logic tick;
    logic tick_clear;
    logic at_edge;

    // Counter restarts on every entry into SWIM (spawn) or HOOKED (hook).
    assign tick_clear = !((state_q == ST_SWIM) || (state_q == ST_HOOKED))
                      || ((state_q == ST_SWIM) && hook);

    fish_tick_gen #(
        .H_DIV(H_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_ni (rst),
        .clear_i(tick_clear),
        .tick_o (tick)
    );

    // Swimmer has reached the screen edge it is heading towards.
    always_comb begin
        at_edge = 1'b0;
        if (way_q == WAY_RIGHT) at_edge = (h_q >= H_MAX_W);
        else                    at_edge = (h_q == '0);
    end

    // Lifecycle state machine and coordinate next-state.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        way_d    = way_q;
        caught_d = caught_q;
        unique case (state_q)
            ST_IDLE: begin
                if (spawn) begin
                    h_d     = spawn_h;
                    v_d     = clamp10(spawn_v, V_MIN_W, V_MAX_W);
                    way_d   = (spawn_way == WAY_RIGHT) ? WAY_RIGHT : WAY_LEFT;
                    state_d = ST_SWIM;
                end
            end
            ST_SWIM: begin
                if (vm) begin
                    if (up) v_d = (v_q <= V_MIN_W) ? V_MIN_W : v_q - 10'd1;
                    else    v_d = (v_q >= V_MAX_W) ? V_MAX_W : v_q + 10'd1;
                end
                if (hook) begin
                    // Hook wins over both the drift step and an edge exit.
                    state_d = ST_HOOKED;
                    way_d   = WAY_UP;
                end else if (tick) begin
                    if (at_edge) begin
                        state_d  = ST_EXIT;
                        caught_d = 1'b0;
                    end else if (way_q == WAY_RIGHT) begin
                        h_d = h_q + 10'd1;
                    end else begin
                        h_d = h_q - 10'd1;
                    end
                end
            end
            ST_HOOKED: begin
                if (tick) begin
                    v_d = (v_q == '0) ? '0 : v_q - 10'd1;
                    // The reel step that lands at or above the surface ends the catch.
                    if ({1'b0, v_q} <= V_REEL_W) begin
                        state_d  = ST_EXIT;
                        caught_d = 1'b1;
                    end
                end
            end
            ST_EXIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        appear_d = (state_d == ST_SWIM) || (state_d == ST_HOOKED);
        done_d   = (state_d == ST_EXIT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            way_q    <= WAY_LEFT;
            appear_q <= 1'b0;
            done_q   <= 1'b0;
            caught_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            way_q    <= way_d;
            appear_q <= appear_d;
            done_q   <= done_d;
            caught_q <= caught_d;
        end
    end

    assign h      = h_q;
    assign v      = v_q;
    assign way    = way_q;
    assign appear = appear_q;
    assign done   = done_q;
    assign caught = caught_q;

endmodule

// File: tb/tb_fish_position.sv
// Bench for fish_position: directed lifecycle scenarios followed by random
// traffic, every cycle compared against a behavioural fish model.
module tb_fish_position;

    localparam int H_DIV = 4;
    localparam int HMAX  = 720;
    localparam int VMIN  = 200;
    localparam int VMAX  = 460;
    localparam int VSURF = 120;

    logic       clk = 1'b0;
    logic       rst, spawn, vm, up, hook;
    logic [1:0] spawn_way;
    logic [9:0] spawn_h, spawn_v;
    logic [9:0] h, v;
    logic [1:0] way;
    logic       appear, done, caught;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: lifecycle phase 0 idle, 1 swim, 2 hooked, 3 exit.
    int m_phase = 0;
    int m_age = 0;
    int m_h = 0, m_v = 0, m_way = 0, m_caught = 0;

    always #5 clk = ~clk;

    fish_position #(
        .H_MAX(HMAX), .V_MIN(VMIN), .V_MAX(VMAX), .V_SURFACE(VSURF), .H_DIV(H_DIV)
    ) dut (
        .clk(clk), .rst(rst), .spawn(spawn), .spawn_way(spawn_way),
        .spawn_h(spawn_h), .spawn_v(spawn_v), .vm(vm), .up(up), .hook(hook),
        .h(h), .v(v), .way(way), .appear(appear), .done(done), .caught(caught)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit tick;
        int nv;
        if (!rst) begin
            m_phase = 0; m_age = 0; m_h = 0; m_v = 0; m_way = 0; m_caught = 0;
            return;
        end
        tick = ((m_age + 1) % H_DIV) == 0;
        case (m_phase)
            0: if (spawn) begin
                m_h = spawn_h;
                m_v = (spawn_v < VMIN) ? VMIN : (spawn_v > VMAX) ? VMAX : int'(spawn_v);
                m_way = (spawn_way == 2'd1) ? 1 : 0;
                m_phase = 1; m_age = 0;
            end
            1: begin
                nv = m_v;
                if (vm) nv = up ? ((m_v - 1 < VMIN) ? VMIN : m_v - 1)
                                : ((m_v + 1 > VMAX) ? VMAX : m_v + 1);
                m_v = nv;
                if (hook) begin
                    m_phase = 2; m_way = 2; m_age = 0;
                end else begin
                    if (tick) begin
                        if ((m_way == 0 && m_h == 0) || (m_way == 1 && m_h >= HMAX)) begin
                            m_phase = 3; m_caught = 0;
                        end else m_h = m_h + ((m_way == 1) ? 1 : -1);
                    end
                    m_age++;
                end
            end
            2: begin
                if (tick) begin
                    if (m_v > 0) m_v = m_v - 1;
                    if (m_v <= VSURF) begin m_phase = 3; m_caught = 1; end
                end
                m_age++;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic step(input logic r, input logic s, input logic [1:0] sw,
                        input logic [9:0] sh, input logic [9:0] sv,
                        input logic vmi, input logic upi, input logic hk);
        rst = r; spawn = s; spawn_way = sw; spawn_h = sh; spawn_v = sv;
        vm = vmi; up = upi; hook = hk;
        @(posedge clk);
        model_edge();
        #1;
        check_val("h", 32'(h), 32'(m_h));
        check_val("v", 32'(v), 32'(m_v));
        check_val("way", 32'(way), 32'(m_way));
        check_val("appear", 32'(appear), 32'(m_phase == 1 || m_phase == 2));
        check_val("done", 32'(done), 32'(m_phase == 3));
        check_val("caught", 32'(caught), 32'(m_caught));
    endtask

    task automatic idle_n(input int n, input logic hk);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, hk);
    endtask

    initial begin
        logic hk_lvl;
        logic [1:0] rw;
        logic [9:0] rh;
        rst = 0; spawn = 0; spawn_way = 0; spawn_h = 0; spawn_v = 0;
        vm = 0; up = 0; hook = 0;

        // Reset values.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle_n(2, 0);

        // Spawn left, swim off the left edge.
        step(1, 1, 0, 10, 300, 0, 0, 0);
        idle_n(50, 0);

        // Spawn right just below the edge; illegal way 3 afterwards maps to left.
        step(1, 1, 1, 719, 300, 0, 0, 0);
        idle_n(12, 0);
        step(1, 1, 3, 2, 900, 0, 0, 0);
        idle_n(16, 0);

        // Vertical clamp at V_MIN, then one step down, and vm on a tick edge.
        step(1, 1, 1, 400, 201, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        // Second spawn while swimming is ignored.
        step(1, 1, 0, 5, 450, 0, 0, 0);
        idle_n(6, 0);

        // Hook and reel to the surface, vm ignored while hooked.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1, i[0], 1);
        idle_n(400, 0);
        idle_n(1400, 0);

        // Hook on the same edge as the left-edge exit tick.
        step(1, 1, 0, 1, 250, 0, 0, 0);
        idle_n(7, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle_n(30, 1);

        // Reset while hooked, then spawn again.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 715, 470, 0, 0, 0);
        idle_n(40, 0);

        // Random traffic.
        hk_lvl = 0;
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 149) == 0) hk_lvl = ~hk_lvl;
            rw = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       rh = 10'($urandom_range(0, 12));
                1:       rh = 10'($urandom_range(708, 730));
                default: rh = 10'($urandom);
            endcase
            step(($urandom_range(0, 599) != 0),
                 ($urandom_range(0, 19) == 0), rw, rh, 10'($urandom),
                 ($urandom_range(0, 2) == 0), 1'($urandom), hk_lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
